// File: rtl/window_buffer_pkg.sv
// Shared types and helpers for the K x K sliding-window generator.
package window_buffer_pkg;

    typedef enum logic {
        PAD_ZERO = 1'b0,
        PAD_REPL = 1'b1
    } pad_mode_e;

    // Bit offset of tap (dy,dx); tap (0,0) sits in the MSBs.
    function automatic int tap_off(input int dy, input int dx, input int k, input int pix_w);
        return (k * k - 1 - (dy * k + dx)) * pix_w;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/window_buffer_line_buffer_ram.sv
// Per-column history of the K-1 previous rows; one read and one write per step.
module line_buffer_ram
    import window_buffer_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 128,
    parameter int unsigned K     = 3
) (
    input  logic                          clock,
    input  logic                          i_we,
    input  logic [$clog2(IMG_W)-1:0]      i_addr,
    input  logic [PIX_W-1:0]              i_pix,
    output logic [(K-1)*PIX_W-1:0]        o_rd_data_c
);

    localparam int unsigned LB_W = (K - 1) * PIX_W;

    logic [LB_W-1:0] r_mem [IMG_W];
    logic [LB_W-1:0] w_wdata;

    // Oldest row in the MSBs; the write drops it and appends the new pixel.
    assign o_rd_data_c = r_mem[i_addr];
    assign w_wdata     = {o_rd_data_c[LB_W-PIX_W-1:0], i_pix};

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_addr] <= w_wdata;
    end

endmodule

// File: rtl/window_buffer.sv
// K x K sliding-window generator with zero/replicate edge padding, handshakes
// on both sides and a virtual raster that flushes the bottom/right borders.
module window_buffer
    import window_buffer_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned K     = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_pad_mode,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [PIX_W-1:0]            i_in_data,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [K*K*PIX_W-1:0]        o_out_window,
    output logic [$clog2(IMG_H)-1:0]    o_out_row,
    output logic [$clog2(IMG_W)-1:0]    o_out_col,
    output logic                        o_frame_done
);

    localparam int unsigned R      = (K - 1) / 2;
    localparam int unsigned WIN_W  = K * K * PIX_W;
    localparam int unsigned LB_W   = (K - 1) * PIX_W;
    localparam int unsigned PY_W   = $clog2(IMG_H + R);
    localparam int unsigned PX_W   = $clog2(IMG_W + R);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ADDR_W = $clog2(IMG_W);

    localparam logic [PY_W-1:0]  Y_IMG    = PY_W'(IMG_H);
    localparam logic [PY_W-1:0]  Y_LAST   = PY_W'(IMG_H + R - 1);
    localparam logic [PY_W-1:0]  Y_R      = PY_W'(R);
    localparam logic [PX_W-1:0]  X_IMG    = PX_W'(IMG_W);
    localparam logic [PX_W-1:0]  X_LAST   = PX_W'(IMG_W + R - 1);
    localparam logic [PX_W-1:0]  X_R      = PX_W'(R);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    logic [PY_W-1:0]   r_y;
    logic [PX_W-1:0]   r_x;
    pad_mode_e         r_pad;
    logic [PIX_W-1:0]  r_taps [K][K];
    logic              r_out_valid;
    logic [WIN_W-1:0]  r_out_window;
    logic [ROW_W-1:0]  r_out_row;
    logic [COL_W-1:0]  r_out_col;
    logic              r_frame_done;

    logic              w_need_in;
    logic              w_emit;
    logic              w_out_free;
    logic              w_adv;
    logic              w_lb_we;
    logic              w_last_hs;
    logic [ADDR_W-1:0] w_addr;
    logic [LB_W-1:0]   w_rd;
    logic [PIX_W-1:0]  w_col   [K];
    logic [PIX_W-1:0]  w_shift [K][K];
    logic [WIN_W-1:0]  w_window;

    assign w_need_in  = (r_y < Y_IMG) && (r_x < X_IMG);
    assign w_emit     = (r_y >= Y_R) && (r_x >= X_R);
    assign w_out_free = !r_out_valid || i_out_ready;
    assign w_adv      = (!w_need_in || i_in_valid) && (!w_emit || w_out_free);
    assign o_in_ready = w_need_in && (!w_emit || w_out_free);
    assign w_lb_we    = w_adv && !i_clear && (r_x < X_IMG);
    assign w_addr     = (r_x < X_IMG) ? ADDR_W'(r_x) : '0;
    assign w_last_hs  = r_out_valid && i_out_ready &&
                        (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);

    line_buffer_ram #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .K     (K)
    ) u_line_buffer (
        .clock       (clock),
        .i_we        (w_lb_we),
        .i_addr      (w_addr),
        .i_pix       (i_in_data),
        .o_rd_data_c (w_rd)
    );

    // Incoming column (oldest row first) and the window after this step's shift.
    always_comb begin
        for (int dy = 0; dy < K - 1; dy++) begin
            w_col[dy] = w_rd[(K - 1 - dy) * PIX_W - 1 -: PIX_W];
        end
        w_col[K-1] = i_in_data;
        for (int dy = 0; dy < K; dy++) begin
            for (int dx = 0; dx < K - 1; dx++) begin
                w_shift[dy][dx] = r_taps[dy][dx+1];
            end
            w_shift[dy][K-1] = w_col[dy];
        end
    end

    // Border taps are resolved purely from the centre coordinate, never from contents.
    always_comb begin : remap
        int cy;
        int cx;
        int sy;
        int sx;
        logic [PIX_W-1:0] pix;
        cy       = int'(r_y) - int'(R);
        cx       = int'(r_x) - int'(R);
        w_window = '0;
        for (int dy = 0; dy < K; dy++) begin
            for (int dx = 0; dx < K; dx++) begin
                sy  = clamp(cy - int'(R) + dy, 0, int'(IMG_H) - 1) - (cy - int'(R));
                sx  = clamp(cx - int'(R) + dx, 0, int'(IMG_W) - 1) - (cx - int'(R));
                pix = '0;
                if ((sy == dy && sx == dx) || r_pad == PAD_REPL) begin
                    for (int a = 0; a < K; a++) begin
                        for (int b = 0; b < K; b++) begin
                            if (a == sy && b == sx) pix = w_shift[a][b];
                        end
                    end
                end
                w_window[tap_off(dy, dx, int'(K), int'(PIX_W)) +: PIX_W] = pix;
            end
        end
    end

    // Virtual raster position and per-frame pad mode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_y   <= '0;
            r_x   <= '0;
            r_pad <= PAD_ZERO;
        end else if (i_clear) begin
            r_y <= '0;
            r_x <= '0;
        end else if (w_adv) begin
            if (r_y == '0 && r_x == '0) r_pad <= pad_mode_e'(i_pad_mode);
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + PY_W'(1);
            end else begin
                r_x <= r_x + PX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_taps <= '{default: '0};
        end else if (w_adv && !i_clear) begin
            r_taps <= w_shift;
        end
    end

    // Output register: holds until accepted, reloads in the same cycle as a handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_window <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= !i_clear && w_last_hs;
            if (i_clear) begin
                r_out_valid <= 1'b0;
            end else if (w_adv && w_emit) begin
                r_out_valid  <= 1'b1;
                r_out_window <= w_window;
                r_out_row    <= ROW_W'(r_y - Y_R);
                r_out_col    <= COL_W'(r_x - X_R);
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_window = r_out_window;
    assign o_out_row    = r_out_row;
    assign o_out_col    = r_out_col;
    assign o_frame_done = r_frame_done;

endmodule
